// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: four requesters share one WIDTH-bit register.
// A round-robin arbiter grants one requester at a time. The winner's data is
// written through a three-state sequence: IDLE -> LOAD -> DONE.
//
// Ports:
//   clk, rst  - single clock; asynchronous active-high reset
//   req[3:0]  - per-requester write request
//   din       - packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt[3:0]  - registered one-hot grant, high during LOAD
//   ack[3:0]  - registered one-hot write-complete pulse, high during DONE
//   Q         - shared register contents
//   owner     - index of the requester that last wrote Q
//   busy      - high whenever the FSM is not in IDLE
//   wr_count  - completed writes, modulo 256
//
// Timing: a request seen at edge T grants in the LOAD cycle after T. Q and
// owner update at edge T+1, and ack pulses in the DONE cycle that follows.
// A new grant can be issued every third cycle at most.

module reg_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         gnt,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   Q,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [7:0]         wr_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] last;    // requester served most recently
  logic [1:0] winner;  // requester owning the current transaction

  // Round-robin pick.
  // The scan starts one past the last served requester and wraps around.
  // At k = 4 it reaches the last served requester itself. That requester
  // therefore wins only when nobody else is asking.
  logic       pick_vld;
  logic [1:0] pick_idx;

  always_comb begin
    logic [1:0] idx;
    pick_vld = 1'b0;
    pick_idx = last;
    idx      = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // Data slice of the latched winner. It is only consumed on the edge that
  // ends LOAD, so din is free to change at any other time.
  logic [WIDTH-1:0] din_sel;
  assign din_sel = din[int'(winner)*WIDTH +: WIDTH];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 2'd3;   // requester 0 gets first priority after reset
      winner   <= 2'd0;
      gnt      <= 4'd0;
      ack      <= 4'd0;
      Q        <= '0;
      owner    <= 2'd0;
      wr_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 4'd0;
          if (pick_vld) begin
            winner <= pick_idx;
            gnt    <= 4'd1 << pick_idx;
            state  <= LOAD;
          end else begin
            gnt <= 4'd0;
          end
        end
        // req is ignored from here on.
        // A requester that drops out after being granted still completes.
        LOAD: begin
          Q     <= din_sel;
          owner <= winner;
          gnt   <= 4'd0;
          ack   <= 4'd1 << winner;
          state <= DONE;
        end
        DONE: begin
          gnt      <= 4'd0;
          ack      <= 4'd0;
          last     <= winner;
          wr_count <= wr_count + 8'd1;  // wraps naturally at 256
          state    <= IDLE;
        end
        default: begin
          gnt   <= 4'd0;
          ack   <= 4'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Grant and completion pulses belong to different states.
  // They can never overlap.
  gnt_ack_excl: assert property (@(posedge clk) disable iff (rst) !((|gnt) && (|ack)));

endmodule
